fifo_rd_ctrl: RTL

- Synchronous FIFO controller that drives the team's dual-port block RAM (`ram_dp`, 2-cycle registered read latency) and consumes its read data.
- Upstream side: valid/ready write stream into the RAM write port.
- Downstream side: valid/ready read stream. A 3-entry output prefetch buffer hides the RAM's 2-cycle read latency, so the stream runs at one word per clock.
- Sits between DSP stages as an elastic buffer.

---
 rtl/fifo_rd_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: elastic FIFO controller over a 2-cycle-latency dual-port RAM with a 3-entry prefetch buffer.
// Optional status outputs (level, almost_full) are built when FIFO_STATUS_EN is defined.
module fifo_rd_ctrl #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 6,
    parameter int DEPTH = 2**ASIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DSIZE-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             ram_wen,
    output logic [ASIZE-1:0] ram_waddr,
    output logic [DSIZE-1:0] ram_wdata,
    output logic [ASIZE-1:0] ram_raddr,
    input  logic [DSIZE-1:0] ram_rdata
`ifdef FIFO_STATUS_EN
    ,
    output logic [ASIZE+1:0] level,
    output logic             almost_full
`endif
);

    localparam logic [ASIZE:0] FULL = (ASIZE+1)'(DEPTH);

    logic [ASIZE:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_count;
    logic [1:0]       inflight_q, inflight_d, obuf_cnt_q, obuf_cnt_d, ins_idx;
    logic [DSIZE-1:0] obuf_q [3];
    logic [DSIZE-1:0] obuf_d [3];
    logic             wr_fire, issue, pop, push;
    logic [2:0]       pipe_occ;

    assign ram_count = wr_ptr_q - rd_ptr_q;
    assign s_ready   = !rst && (ram_count != FULL);
    assign wr_fire   = s_valid && s_ready;
    assign ram_wen   = wr_fire;
    assign ram_waddr = wr_ptr_q[ASIZE-1:0];
    assign ram_wdata = s_data;
    assign ram_raddr = rd_ptr_q[ASIZE-1:0];

    assign m_valid = obuf_cnt_q != 2'd0;
    assign m_data  = obuf_q[0];
    assign pop     = m_valid && m_ready;
    assign push    = inflight_q[1];

    // A pop this cycle frees its slot, so issue can continue at one word per clock.
    assign pipe_occ = 3'(inflight_q[0]) + 3'(inflight_q[1]) + 3'(obuf_cnt_q) - 3'(pop);
    assign issue    = (ram_count != '0) && (pipe_occ < 3'd3);

    assign wr_ptr_d   = wr_ptr_q + (ASIZE+1)'(wr_fire);
    assign rd_ptr_d   = rd_ptr_q + (ASIZE+1)'(issue);
    assign inflight_d = {inflight_q[0], issue};
    assign ins_idx    = obuf_cnt_q - 2'(pop);
    assign obuf_cnt_d = obuf_cnt_q - 2'(pop) + 2'(push);

    always_comb begin
        obuf_d[0] = (push && ins_idx == 2'd0) ? ram_rdata : pop ? obuf_q[1] : obuf_q[0];
        obuf_d[1] = (push && ins_idx == 2'd1) ? ram_rdata : pop ? obuf_q[2] : obuf_q[1];
        obuf_d[2] = (push && ins_idx == 2'd2) ? ram_rdata : obuf_q[2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            obuf_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            obuf_cnt_q <= obuf_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        obuf_q <= obuf_d;
    end

`ifdef FIFO_STATUS_EN
    logic [ASIZE:0] ram_count_d;

    assign ram_count_d = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            level       <= (ASIZE+2)'(ram_count_d) + (ASIZE+2)'(inflight_d[0])
                         + (ASIZE+2)'(inflight_d[1]) + (ASIZE+2)'(obuf_cnt_d);
            almost_full <= ram_count_d >= (ASIZE+1)'(DEPTH-4);
        end
    end
`endif

endmodule
